// File: rtl/sram_ecc_scrubber.sv
// Background ECC scrub controller: walks every SRAM word, counts decoder errors and
// optionally writes corrected data back (write-back exists only when SCRUB_WB_EN is defined).
module sram_ecc_scrubber #(
    parameter int unsigned WDTH   = 34,
    parameter int unsigned AW     = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned INTV_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic [INTV_W-1:0] i_intv,
    input  logic              i_clr_cnt,
    output logic              o_req,
    output logic              o_we,
    output logic [AW-1:0]     o_addr,
    output logic [WDTH-1:0]   o_wdata,
    input  logic              i_gnt,
    input  logic [WDTH-1:0]   i_dec_data,
    input  logic              i_dec_err_detect,
    input  logic              i_dec_err_multpl,
    output logic              o_busy,
    output logic              o_pass_done,
    output logic [15:0]       o_cor_cnt,
    output logic [15:0]       o_unc_cnt,
    output logic              o_unc_vld,
    output logic [AW-1:0]     o_unc_addr
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
`ifdef SCRUB_WB_EN
        S_WB_REQ,
`endif
        S_NEXT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [INTV_W-1:0]   intv_cnt;
    logic [LAT_W-1:0]    lat_cnt;
    logic [AW-1:0]       addr;
    logic [WDTH-1:0]     wdata;
    logic [15:0]         cor_cnt;
    logic [15:0]         unc_cnt;
    logic                unc_vld;
    logic [AW-1:0]       unc_addr;
    logic                req_q;
    logic                busy_q;
    logic                pass_q;

    logic                load_intv;
    logic                load_lat;
    logic                sample;
    logic                advance;
    logic                cor_hit;
    logic                unc_hit;

    assign cor_hit = sample && i_dec_err_detect && !i_dec_err_multpl;
    assign unc_hit = sample && i_dec_err_multpl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_intv  = 1'b0;
        load_lat   = 1'b0;
        sample     = 1'b0;
        advance    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_en) begin
                    load_intv  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (intv_cnt == '0) begin
                    state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (i_gnt) begin
                    load_lat   = 1'b1;
                    state_next = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    sample     = 1'b1;
                    state_next = S_NEXT;
`ifdef SCRUB_WB_EN
                    if (i_dec_err_detect && !i_dec_err_multpl) begin
                        state_next = S_WB_REQ;
                    end
`endif
                end
            end
`ifdef SCRUB_WB_EN
            S_WB_REQ: begin
                if (i_gnt) begin
                    state_next = S_NEXT;
                end
            end
`endif
            S_NEXT: begin
                advance = 1'b1;
                if (i_en) begin
                    load_intv  = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Request flags are registered from the next state so o_req rises with the request
    // state and holds, unchanged, until the grant edge moves the FSM on.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            pass_q   <= 1'b0;
            intv_cnt <= '0;
            lat_cnt  <= '0;
            addr     <= '0;
        end else begin
`ifdef SCRUB_WB_EN
            req_q <= (state_next == S_RD_REQ) || (state_next == S_WB_REQ);
`else
            req_q <= (state_next == S_RD_REQ);
`endif
            busy_q <= (state_next != S_IDLE);
            pass_q <= advance && (addr == AW'(DEPTH - 1));

            if (load_intv) begin
                intv_cnt <= i_intv;
            end else if ((state == S_WAIT) && (intv_cnt != '0)) begin
                intv_cnt <= intv_cnt - 1'b1;
            end

            if (load_lat) begin
                lat_cnt <= LAT_W'(RD_LAT - 1);
            end else if ((state == S_RD_WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - 1'b1;
            end

            if (advance) begin
                addr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
            end
        end
    end

    // A clear in the same cycle as an error suppresses that error's count and capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wdata    <= '0;
            cor_cnt  <= '0;
            unc_cnt  <= '0;
            unc_vld  <= 1'b0;
            unc_addr <= '0;
        end else begin
            if (cor_hit) begin
                wdata <= i_dec_data;
            end
            if (i_clr_cnt) begin
                cor_cnt  <= '0;
                unc_cnt  <= '0;
                unc_vld  <= 1'b0;
                unc_addr <= '0;
            end else begin
                if (cor_hit && (cor_cnt != '1)) begin
                    cor_cnt <= cor_cnt + 1'b1;
                end
                if (unc_hit) begin
                    if (unc_cnt != '1) begin
                        unc_cnt <= unc_cnt + 1'b1;
                    end
                    if (!unc_vld) begin
                        unc_vld  <= 1'b1;
                        unc_addr <= addr;
                    end
                end
            end
        end
    end

`ifdef SCRUB_WB_EN
    logic we_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q <= 1'b0;
        end else begin
            we_q <= (state_next == S_WB_REQ);
        end
    end

    assign o_we = we_q;
`else
    assign o_we = '0;
`endif

    assign o_req       = req_q;
    assign o_addr      = addr;
    assign o_wdata     = wdata;
    assign o_busy      = busy_q;
    assign o_pass_done = pass_q;
    assign o_cor_cnt   = cor_cnt;
    assign o_unc_cnt   = unc_cnt;
    assign o_unc_vld   = unc_vld;
    assign o_unc_addr  = unc_addr;

endmodule
